hazard_scoreboard_unit: RTL and testbench

HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

---
 rtl/hazard_scoreboard_unit.sv | 138 +++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - pipeline hazard detection, forwarding select and long-op scoreboard
module hazard_scoreboard_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  localparam int NUM_REGS = 2 ** REG_AW
) (
  input  logic                clk,
  input  logic                rst_n,
  // decode stage
  input  logic [REG_AW-1:0]   rs1_d,
  input  logic [REG_AW-1:0]   rs2_d,
  input  logic [REG_AW-1:0]   rd_d,
  input  logic                reg_write_d,
  input  logic                long_op_d,
  // execute stage
  input  logic [REG_AW-1:0]   rs1_e,
  input  logic [REG_AW-1:0]   rs2_e,
  input  logic [REG_AW-1:0]   rd_e,
  input  logic                load_e,
  input  logic                long_issue_e,
  input  logic [1:0]          pc_src_e,
  // memory stage
  input  logic [REG_AW-1:0]   rd_m,
  input  logic                reg_write_m,
  input  logic                load_m,
  // writeback stage
  input  logic [REG_AW-1:0]   rd_w,
  input  logic                reg_write_w,
  // multicycle unit
  input  logic                long_busy,
  input  logic                long_done,
  input  logic [REG_AW-1:0]   long_rd,
  // counter control
  input  logic                cnt_clr,
  // pipeline control
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_d,
  output logic                flush_e,
  output logic [1:0]          forward_a_e,
  output logic [1:0]          forward_b_e,
  // scoreboard and statistics
  output logic [NUM_REGS-1:0] sb_pending,
  output logic [REG_AW:0]     sb_count,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam logic [REG_AW-1:0] REG_ZERO = '0;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam bit                LOAD_M_CHECK = (LOAD_LAT == 2);

  logic                load_stall;
  logic                sb_stall;
  logic                struct_stall;
  logic                any_stall;
  logic                redirect;
  logic [NUM_REGS-1:0] sb_next;

  // Forwarding select: the younger M result wins over W; x0 is never forwarded.
  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    if (reg_write_m && rs1_e != REG_ZERO && rs1_e == rd_m) begin
      forward_a_e = 2'b10;
    end else if (reg_write_w && rs1_e != REG_ZERO && rs1_e == rd_w) begin
      forward_a_e = 2'b01;
    end
    if (reg_write_m && rs2_e != REG_ZERO && rs2_e == rd_m) begin
      forward_b_e = 2'b10;
    end else if (reg_write_w && rs2_e != REG_ZERO && rs2_e == rd_w) begin
      forward_b_e = 2'b01;
    end
  end

  // Stall sources: load-use distance, scoreboard RAW/WAW, and multicycle unit occupancy.
  always_comb begin
    load_stall = load_e && rd_e != REG_ZERO && (rs1_d == rd_e || rs2_d == rd_e);
    if (LOAD_M_CHECK && load_m && rd_m != REG_ZERO && (rs1_d == rd_m || rs2_d == rd_m)) begin
      load_stall = 1'b1;
    end
    sb_stall = (sb_pending[rs1_d] && rs1_d != REG_ZERO)
            || (sb_pending[rs2_d] && rs2_d != REG_ZERO)
            || (reg_write_d && rd_d != REG_ZERO && sb_pending[rd_d]);
    struct_stall = long_op_d && (long_busy || long_issue_e);
  end

  // Pipeline control: a taken redirect kills the D instruction, so it must never stall.
  always_comb begin
    any_stall = load_stall || sb_stall || struct_stall;
    redirect  = |pc_src_e;
    stall_f   = any_stall && !redirect;
    stall_d   = any_stall && !redirect;
    flush_d   = redirect;
    flush_e   = redirect || any_stall;
  end

  // Scoreboard next state: clear on completion first so a same-cycle issue wins.
  always_comb begin
    sb_next = sb_pending;
    if (long_done && long_rd != REG_ZERO) begin
      sb_next[long_rd] = 1'b0;
    end
    if (long_issue_e && rd_e != REG_ZERO) begin
      sb_next[rd_e] = 1'b1;
    end
    sb_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_pending <= '0;
    end else begin
      sb_pending <= sb_next;
    end
  end

  // Population count of the scoreboard, same-cycle with sb_pending.
  always_comb begin
    sb_count = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sb_count = sb_count + {{REG_AW{1'b0}}, sb_pending[i]};
    end
  end

  // Saturating stall counter; clear takes priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall_d && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - self-checking bench for hazard_scoreboard_unit
module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic       reg_write_d, long_op_d;
  logic [4:0] rs1_e, rs2_e, rd_e;
  logic       load_e, long_issue_e;
  logic [1:0] pc_src_e;
  logic [4:0] rd_m;
  logic       reg_write_m, load_m;
  logic [4:0] rd_w;
  logic       reg_write_w;
  logic       long_busy, long_done;
  logic [4:0] long_rd;
  logic       cnt_clr;

  logic        stall_f1, stall_d1, flush_d1, flush_e1;
  logic [1:0]  fa1, fb1;
  logic [31:0] pend1;
  logic [5:0]  count1;
  logic [3:0]  cnt1;
  logic        stall_f2, stall_d2, flush_d2, flush_e2;
  logic [1:0]  fa2, fb2;
  logic [31:0] pend2;
  logic [5:0]  count2;
  logic [3:0]  cnt2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .reg_write_d(reg_write_d), .long_op_d(long_op_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .load_e(load_e), .long_issue_e(long_issue_e),
    .pc_src_e(pc_src_e), .rd_m(rd_m), .reg_write_m(reg_write_m), .load_m(load_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w),
    .long_busy(long_busy), .long_done(long_done), .long_rd(long_rd), .cnt_clr(cnt_clr),
    .stall_f(stall_f1), .stall_d(stall_d1), .flush_d(flush_d1), .flush_e(flush_e1),
    .forward_a_e(fa1), .forward_b_e(fb1),
    .sb_pending(pend1), .sb_count(count1), .stall_cnt(cnt1)
  );

  hazard_scoreboard_unit #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .reg_write_d(reg_write_d), .long_op_d(long_op_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .load_e(load_e), .long_issue_e(long_issue_e),
    .pc_src_e(pc_src_e), .rd_m(rd_m), .reg_write_m(reg_write_m), .load_m(load_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w),
    .long_busy(long_busy), .long_done(long_done), .long_rd(long_rd), .cnt_clr(cnt_clr),
    .stall_f(stall_f2), .stall_d(stall_d2), .flush_d(flush_d2), .flush_e(flush_e2),
    .forward_a_e(fa2), .forward_b_e(fb2),
    .sb_pending(pend2), .sb_count(count2), .stall_cnt(cnt2)
  );

  // Reference model: set of pending registers and two plain integer stall counters.
  bit m_pend [32];
  int m_cnt1 = 0;
  int m_cnt2 = 0;

  function automatic logic [1:0] m_fwd(logic [4:0] rs);
    if (rs != 0 && reg_write_m && rs == rd_m) return 2'b10;
    if (rs != 0 && reg_write_w && rs == rd_w) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_hazard(int lat);
    bit ld, sb, st;
    ld = load_e && rd_e != 0 && (rs1_d == rd_e || rs2_d == rd_e);
    if (lat == 2 && load_m && rd_m != 0 && (rs1_d == rd_m || rs2_d == rd_m)) ld = 1;
    sb = (rs1_d != 0 && m_pend[rs1_d]) || (rs2_d != 0 && m_pend[rs2_d])
      || (reg_write_d && rd_d != 0 && m_pend[rd_d]);
    st = long_op_d && (long_busy || long_issue_e);
    return ld || sb || st;
  endfunction

  function automatic bit m_stall(int lat);
    return m_hazard(lat) && pc_src_e == 2'b00;
  endfunction

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  // Model state update on the clock edge, cleared asynchronously by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_pend[i] <= 1'b0;
      m_cnt1 <= 0;
      m_cnt2 <= 0;
    end else begin
      if (long_done && long_rd != 0) m_pend[long_rd] <= 1'b0;
      if (long_issue_e && rd_e != 0) m_pend[rd_e] <= 1'b1;
      m_cnt1 <= cnt_clr ? 0 : (m_stall(1) ? ((m_cnt1 + 1 > 15) ? 15 : m_cnt1 + 1) : m_cnt1);
      m_cnt2 <= cnt_clr ? 0 : (m_stall(2) ? ((m_cnt2 + 1 > 15) ? 15 : m_cnt2 + 1) : m_cnt2);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("stall_f1", 64'(stall_f1), 64'(m_stall(1)));
    chk("stall_d1", 64'(stall_d1), 64'(m_stall(1)));
    chk("flush_d1", 64'(flush_d1), 64'(pc_src_e != 0));
    chk("flush_e1", 64'(flush_e1), 64'(pc_src_e != 0 || m_hazard(1)));
    chk("fwd_a1", 64'(fa1), 64'(m_fwd(rs1_e)));
    chk("fwd_b1", 64'(fb1), 64'(m_fwd(rs2_e)));
    chk("pend1", 64'(pend1), 64'(m_pend_vec()));
    chk("count1", 64'(count1), 64'(m_count()));
    chk("cnt1", 64'(cnt1), 64'(m_cnt1));
    chk("stall_d2", 64'(stall_d2), 64'(m_stall(2)));
    chk("stall_f2", 64'(stall_f2), 64'(m_stall(2)));
    chk("flush_e2", 64'(flush_e2), 64'(pc_src_e != 0 || m_hazard(2)));
    chk("flush_d2", 64'(flush_d2), 64'(pc_src_e != 0));
    chk("fwd_a2", 64'(fa2), 64'(m_fwd(rs1_e)));
    chk("fwd_b2", 64'(fb2), 64'(m_fwd(rs2_e)));
    chk("pend2", 64'(pend2), 64'(m_pend_vec()));
    chk("count2", 64'(count2), 64'(m_count()));
    chk("cnt2", 64'(cnt2), 64'(m_cnt2));
  end

  task automatic clr_in();
    rs1_d = 0; rs2_d = 0; rd_d = 0; reg_write_d = 0; long_op_d = 0;
    rs1_e = 0; rs2_e = 0; rd_e = 0; load_e = 0; long_issue_e = 0; pc_src_e = 0;
    rd_m = 0; reg_write_m = 0; load_m = 0; rd_w = 0; reg_write_w = 0;
    long_busy = 0; long_done = 0; long_rd = 0; cnt_clr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0;
    clr_in();
    #3;
    chk("rst_pend", 64'(pend1), 64'h0);
    chk("rst_count", 64'(count1), 64'h0);
    chk("rst_cnt", 64'(cnt1), 64'h0);
    step();
    rst_n = 1;
    step();

    // load-use hazard and x0 destination
    load_e = 1; rd_e = 5; rs1_d = 5; #1;
    chk("lu_stall_f", 64'(stall_f1), 64'h1);
    chk("lu_stall_d", 64'(stall_d1), 64'h1);
    chk("lu_flush_e", 64'(flush_e1), 64'h1);
    chk("lu_flush_d", 64'(flush_d1), 64'h0);
    rd_e = 0; #1;
    chk("lu0_outs", 64'({stall_f1, stall_d1, flush_d1, flush_e1}), 64'h0);
    step(); clr_in();

    // load in M only matters at distance 2
    load_m = 1; rd_m = 7; rs2_d = 7; #1;
    chk("ll2_stall", 64'(stall_d2), 64'h1);
    chk("ll1_stall", 64'(stall_d1), 64'h0);
    step(); clr_in();

    // forwarding
    rd_m = 3; rd_w = 3; reg_write_m = 1; reg_write_w = 1; rs1_e = 3; #1;
    chk("fwd_m", 64'(fa1), 64'h2);
    rs1_e = 0; rd_m = 0; #1;
    chk("fwd_x0", 64'(fa1), 64'h0);
    rs2_e = 3; reg_write_m = 0; rd_m = 3; #1;
    chk("fwd_w", 64'(fb1), 64'h1);
    step(); clr_in();

    // scoreboard set, RAW stall until completion
    long_issue_e = 1; rd_e = 9;
    step(); clr_in(); rs1_d = 9; #1;
    chk("sb_set", 64'(pend1[9]), 64'h1);
    chk("sb_count1", 64'(count1), 64'h1);
    chk("sb_raw", 64'(stall_d1), 64'h1);
    step();
    long_done = 1; long_rd = 9; #1;
    chk("sb_raw_done", 64'(stall_d1), 64'h1);
    step(); long_done = 0; #1;
    chk("sb_released", 64'(stall_d1), 64'h0);
    chk("sb_cleared", 64'(count1), 64'h0);

    // same-cycle set and clear, set wins
    long_issue_e = 1; rd_e = 9;
    step(); long_done = 1; long_rd = 9;
    step(); clr_in(); #1;
    chk("sb_setwins", 64'(pend1[9]), 64'h1);
    long_done = 1; long_rd = 4;
    step(); clr_in(); #1;
    chk("sb_nonpend", 64'(count1), 64'h1);
    long_issue_e = 1; rd_e = 0;
    step(); clr_in(); #1;
    chk("sb_x0", 64'(pend1), 64'h200);

    // redirect priority over scoreboard stall
    rs1_d = 9; pc_src_e = 2'b01; #1;
    chk("pri_stall", 64'({stall_f1, stall_d1}), 64'h0);
    chk("pri_flush", 64'({flush_d1, flush_e1}), 64'h3);
    clr_in(); reg_write_d = 1; rd_d = 9; #1;
    chk("waw", 64'(stall_d1), 64'h1);
    reg_write_d = 0; #1;
    chk("waw_nowrite", 64'(stall_d1), 64'h0);

    // structural hazard
    clr_in(); long_op_d = 1; long_busy = 1; #1;
    chk("struct_busy", 64'(stall_d1), 64'h1);
    long_busy = 0; long_issue_e = 1; #1;
    chk("struct_issue", 64'(stall_d1), 64'h1);
    long_issue_e = 0; #1;
    chk("struct_idle", 64'(stall_d1), 64'h0);
    clr_in(); long_done = 1; long_rd = 9;
    step(); clr_in();

    // saturating counter
    cnt_clr = 1;
    step(); cnt_clr = 0; #1;
    chk("cnt_zero", 64'(cnt1), 64'h0);
    load_e = 1; rd_e = 5; rs1_d = 5;
    repeat (20) step();
    chk("cnt_sat", 64'(cnt1), 64'hf);
    chk("cnt_sat2", 64'(cnt2), 64'hf);
    cnt_clr = 1;
    step(); #1;
    chk("cnt_clr_pri", 64'(cnt1), 64'h0);
    clr_in();

    // asynchronous reset mid-cycle
    long_issue_e = 1; rd_e = 9;
    step(); rd_e = 12;
    step(); clr_in(); rs1_d = 9; #1;
    chk("pre_rst_count", 64'(count1), 64'h2);
    chk("pre_rst_stall", 64'(stall_d1), 64'h1);
    rst_n = 0; #1;
    chk("arst_pend", 64'(pend1), 64'h0);
    chk("arst_count", 64'(count1), 64'h0);
    chk("arst_stall", 64'(stall_d1), 64'h0);
    step(); rst_n = 1;
    step(); step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
